// File: rtl/evm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : evm_pkg
// Description : Shared definitions for the result readout unit: default
//               parameter values, field widths, record tag codes, the FSM
//               state encoding and the packed record layout.
// Revision    : 1.0 - initial release
// ============================================================================
package evm_pkg;

  // Default parameter values
  localparam int DEF_NUM_CAND  = 3;
  localparam int DEF_NUM_VOTER = 4;
  localparam int DEF_CNT_W     = 4;

  // Fixed field widths of the record interface
  localparam int TAG_W   = 2;
  localparam int IDX_W   = 2;
  localparam int VAL_W   = 6;
  localparam int VOTED_W = 3;

  // Record tag codes
  localparam logic [TAG_W-1:0] TAG_CAND   = 2'b00;
  localparam logic [TAG_W-1:0] TAG_TOTAL  = 2'b01;
  localparam logic [TAG_W-1:0] TAG_VOTED  = 2'b10;
  localparam logic [TAG_W-1:0] TAG_WINNER = 2'b11;

  // Readout FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_SEND = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // One output record
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] index;
    logic [VAL_W-1:0] value;
  } rec_t;

endpackage : evm_pkg
`default_nettype wire

// File: rtl/max_tracker.sv
`default_nettype none
// ============================================================================
// Module      : max_tracker
// Description : Running-maximum tracker. Fed one (index, count) pair per
//               enabled cycle; keeps the largest count, the lowest index
//               holding it, and a tie flag.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               clear           - restart tracking (new readout)
//               en              - a valid (index, count) pair is present
//               index, count    - candidate being examined
//               max_index       - lowest index of the largest count so far
//               max_count       - largest count so far
//               tie             - largest count seen more than once
// Revision    : 1.0 - initial release
// ============================================================================
module max_tracker
  import evm_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [IDX_W-1:0] index,
  input  logic [CNT_W-1:0] count,
  output logic [IDX_W-1:0] max_index,
  output logic [CNT_W-1:0] max_count,
  output logic             tie
);

  logic [IDX_W-1:0] r_max_index;
  logic [CNT_W-1:0] r_max_count;
  logic             r_tie;

  // The maximum starts at zero, so a zero-count first candidate already
  // registers as a tie; this is what makes an all-zero tally report tie=1.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_max_index <= '0;
      r_max_count <= '0;
      r_tie       <= 1'b0;
    end else if (en) begin
      if (count > r_max_count) begin
        r_max_count <= count;
        r_max_index <= index;
        r_tie       <= 1'b0;
      end else if (count == r_max_count) begin
        r_tie       <= 1'b1;   // keep the lower index already held
      end
    end
  end

  assign max_index = r_max_index;
  assign max_count = r_max_count;
  assign tie       = r_tie;

endmodule : max_tracker
`default_nettype wire

// File: rtl/result_readout_unit.sv
`default_nettype none
// ============================================================================
// Module      : result_readout_unit
// Description : Snapshots the candidate tally and voter status words, scans
//               the candidates one per cycle (total, running maximum, voted
//               count) and then streams NUM_CAND+3 records over a
//               valid/ready handshake: one per candidate, total votes,
//               voters voted and the winner.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               candidate_counts  - flattened tally, candidate i at [i*CNT_W +: CNT_W]
//               voter_status      - flattened status words, nonzero = voted
//               start             - readout request (honoured in IDLE only)
//               busy              - readout in progress
//               rec_valid/ready   - record handshake
//               rec_tag/index/value - current record
//               winner, tie, done - summary and one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module result_readout_unit
  import evm_pkg::*;
#(
  parameter int NUM_CAND  = DEF_NUM_CAND,
  parameter int NUM_VOTER = DEF_NUM_VOTER,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CAND*CNT_W-1:0] candidate_counts,
  input  logic [NUM_VOTER*CNT_W-1:0] voter_status,
  input  logic                      start,
  output logic                      busy,
  output logic                      rec_valid,
  input  logic                      rec_ready,
  output logic [TAG_W-1:0]          rec_tag,
  output logic [IDX_W-1:0]          rec_index,
  output logic [VAL_W-1:0]          rec_value,
  output logic [IDX_W-1:0]          winner,
  output logic                      tie,
  output logic                      done
);

  localparam int PTR_W = $clog2(NUM_CAND + 3);
  localparam logic [IDX_W-1:0] C_SCAN_LAST = IDX_W'(NUM_CAND - 1);
  localparam logic [PTR_W-1:0] C_PTR_TOTAL = PTR_W'(NUM_CAND);
  localparam logic [PTR_W-1:0] C_PTR_VOTED = PTR_W'(NUM_CAND + 1);
  localparam logic [PTR_W-1:0] C_PTR_LAST  = PTR_W'(NUM_CAND + 2);

  state_t                     r_state;
  logic [NUM_CAND*CNT_W-1:0]  r_counts;
  logic [NUM_VOTER*CNT_W-1:0] r_voters;
  logic [IDX_W-1:0]           r_scan_idx;
  logic [PTR_W-1:0]           r_ptr;
  logic [VAL_W-1:0]           r_total;
  logic [VOTED_W-1:0]         r_voted;
  logic                       r_busy;
  logic                       r_valid;
  rec_t                       r_rec;
  logic [IDX_W-1:0]           r_winner;
  logic                       r_tie;
  logic                       r_done;

  logic [CNT_W-1:0]   w_cnt [NUM_CAND];
  logic [VOTED_W-1:0] w_voted;
  logic [PTR_W-1:0]   w_sel_ptr;
  logic [IDX_W-1:0]   w_cidx;
  rec_t               w_rec;
  logic               w_accept;
  logic [IDX_W-1:0]   w_max_index;
  logic [CNT_W-1:0]   w_max_count;
  logic               w_max_tie;

  assign w_accept = (r_state == ST_IDLE) && start;

  // Unpack the snapshot so candidates can be selected by index
  for (genvar g = 0; g < NUM_CAND; g++) begin : g_unpack
    assign w_cnt[g] = r_counts[g*CNT_W +: CNT_W];
  end

  // Number of voters with a nonzero status word in the snapshot
  always_comb begin
    w_voted = '0;
    for (int v = 0; v < NUM_VOTER; v++) begin
      if (r_voters[v*CNT_W +: CNT_W] != '0) begin
        w_voted = w_voted + VOTED_W'(1);
      end
    end
  end

  // Record to load next: record 0 when leaving SCAN, otherwise the one
  // after the record currently presented.
  always_comb begin
    w_sel_ptr = (r_state == ST_SCAN) ? '0 : r_ptr + PTR_W'(1);
    w_cidx    = (w_sel_ptr < C_PTR_TOTAL) ? w_sel_ptr[IDX_W-1:0] : '0;
    w_rec     = '0;
    if (w_sel_ptr < C_PTR_TOTAL) begin
      w_rec.tag   = TAG_CAND;
      w_rec.index = w_cidx;
      w_rec.value = VAL_W'(w_cnt[w_cidx]);
    end else if (w_sel_ptr == C_PTR_TOTAL) begin
      w_rec.tag   = TAG_TOTAL;
      w_rec.value = r_total;
    end else if (w_sel_ptr == C_PTR_VOTED) begin
      w_rec.tag   = TAG_VOTED;
      w_rec.value = VAL_W'(r_voted);
    end else begin
      w_rec.tag   = TAG_WINNER;
      w_rec.index = w_max_index;
      w_rec.value = VAL_W'(w_max_count);
    end
  end

  max_tracker #(
    .CNT_W (CNT_W)
  ) u_max_tracker (
    .clk       (clk),
    .reset     (reset),
    .clear     (w_accept),
    .en        (r_state == ST_SCAN),
    .index     (r_scan_idx),
    .count     (w_cnt[r_scan_idx]),
    .max_index (w_max_index),
    .max_count (w_max_count),
    .tie       (w_max_tie)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_counts   <= '0;
      r_voters   <= '0;
      r_scan_idx <= '0;
      r_ptr      <= '0;
      r_total    <= '0;
      r_voted    <= '0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_rec      <= '0;
      r_winner   <= '0;
      r_tie      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_counts   <= candidate_counts;
            r_voters   <= voter_status;
            r_scan_idx <= '0;
            r_ptr      <= '0;
            r_total    <= '0;
            r_voted    <= '0;
            r_busy     <= 1'b1;
            r_winner   <= '0;
            r_tie      <= 1'b0;
            r_state    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          r_total <= r_total + VAL_W'(w_cnt[r_scan_idx]);
          if (r_scan_idx == '0) begin
            r_voted <= w_voted;
          end
          if (r_scan_idx == C_SCAN_LAST) begin
            r_valid <= 1'b1;
            r_rec   <= w_rec;
            r_ptr   <= '0;
            r_state <= ST_SEND;
          end else begin
            r_scan_idx <= r_scan_idx + IDX_W'(1);
          end
        end
        ST_SEND: begin
          if (rec_ready) begin
            if (r_ptr == C_PTR_LAST) begin
              r_valid  <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_rec    <= '0;
              r_winner <= w_max_index;
              r_tie    <= w_max_tie;
              r_state  <= ST_DONE;
            end else begin
              r_ptr <= r_ptr + PTR_W'(1);
              r_rec <= w_rec;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign rec_valid = r_valid;
  assign rec_tag   = r_rec.tag;
  assign rec_index = r_rec.index;
  assign rec_value = r_rec.value;
  assign winner    = r_winner;
  assign tie       = r_tie;
  assign done      = r_done;

endmodule : result_readout_unit
`default_nettype wire

// File: doc/result_readout_unit.md
RESULT_READOUT_UNIT -- requirements
Module: result_readout_unit

Interface
REQ-001 The block SHALL have parameters (name, default, meaning): NUM_CAND, 3, number of candidates; NUM_VOTER, 4, number of voters; CNT_W, 4, width of each candidate count and each voter status word.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 candidate_counts  input  NUM_CAND*CNT_W  flattened tally from the vote memory; candidate i occupies bits [i*CNT_W +: CNT_W].
REQ-005 voter_status  input  NUM_VOTER*CNT_W  flattened voter status words; a nonzero word means that voter has voted.
REQ-006 start  input  1  single-cycle request to read out the results.
REQ-007 busy  output  1  high from the edge that accepts start until the edge that completes the final record.
REQ-008 rec_valid  output  1  record available.
REQ-009 rec_ready  input  1  consumer accepts the record.
REQ-010 rec_tag  output  2  record type: 00 candidate, 01 total votes, 10 voters voted, 11 winner.
REQ-011 rec_index  output  2  candidate index for tags 00 and 11; 0 otherwise.
REQ-012 rec_value  output  6  record payload, zero-extended.
REQ-013 winner, tie, done  output  2, 1, 1  registered summary: winner index, tie flag, and a one-cycle completion pulse.

Function
REQ-014 FSM states SHALL be IDLE, SCAN, SEND and DONE.
REQ-015 In IDLE, start=1 SHALL snapshot candidate_counts and voter_status into internal registers, clear the accumulators, set busy, and move to SCAN.
REQ-016 start SHALL be ignored in every state other than IDLE.
REQ-017 SCAN SHALL process one candidate per cycle, index 0 to NUM_CAND-1, accumulating the total and a running maximum with its index.
- A strictly greater count SHALL replace the maximum.
- An equal count SHALL set tie and keep the lower index.
- A greater count SHALL clear tie.
REQ-018 In the same SCAN window, the block SHALL count the voters with a nonzero status into a 3-bit voted count.
REQ-019 rec_valid SHALL go high on the NUM_CAND-th rising edge after the edge that accepted start.
REQ-020 SEND SHALL emit exactly NUM_CAND+3 records in this order:
- candidates 0..NUM_CAND-1 (tag 00, index i, value = count);
- total votes (tag 01);
- voters voted (tag 10);
- winner (tag 11, index = winner, value = winner's count).
REQ-021 A record transfers on an edge where rec_valid=1 and rec_ready=1; the next record (or deassertion) SHALL appear on that edge.
REQ-022 While rec_valid=1 and rec_ready=0, rec_tag, rec_index and rec_value SHALL hold stable for any number of cycles.
REQ-023 On transfer of the winner record the FSM SHALL enter DONE.
- done SHALL pulse for exactly one cycle.
- busy and rec_valid SHALL go low.
- The FSM SHALL return to IDLE on the next edge.
REQ-024 The total SHALL be 6 bits wide and SHALL not overflow for NUM_CAND*(2^CNT_W-1) <= 63.
REQ-025 If all counts are equal, including all zero, the outputs SHALL be winner=0 and tie=1.
REQ-026 winner and tie SHALL hold their last values until the next accepted start.
REQ-027 Input changes after the snapshot SHALL NOT affect an ongoing readout.

Reset
REQ-028 On reset the block SHALL:
- enter IDLE;
- drive busy, rec_valid, done, tie, winner, rec_tag, rec_index and rec_value to 0;
- clear the accumulators.
REQ-029 Reset asserted mid-SCAN or mid-SEND SHALL abort the readout; rec_valid SHALL be 0 after that edge and no done pulse SHALL occur.
REQ-030 reset SHALL take priority over start in the same cycle.

Structure
REQ-031 The record tag codes, FSM state encoding and default parameter values SHALL live in a shared package, evm_pkg.
REQ-032 The running-maximum compare SHALL be one sub-module, max_tracker, with inputs clear, en, index and count and outputs max_index, max_count and tie.

Verification
REQ-033 Counts {2,1,1}, all four voters nonzero, start, rec_ready=1 -> records (00,0,2) (00,1,1) (00,2,1) (01,0,4) (10,0,4) (11,0,2); winner=0, tie=0, one done pulse.
REQ-034 Counts {1,3,3}, voters {1,0,1,1} -> winner=1, tie=1, total=7, voted=3.
REQ-035 Counts {0,0,0} -> winner=0, tie=1, all record values 0.
REQ-036 Hold rec_ready=0 for 5 cycles on the second record -> tag, index and value stable; the sequence resumes unchanged.
REQ-037 Assert reset while the third record is pending -> rec_valid and busy are 0 after that edge, no done pulse; a new start then produces a full, correct sequence.
REQ-038 Pulse start while busy, and change candidate_counts during SEND -> no restart and unchanged record values.
